// File: rtl/rst_stage_seq.sv
// Staged reset release sequencer: releases NUM_STAGES active-low domain resets in order,
// one every STRETCH_CYC cycles, with a software soft-reset request/acknowledge handshake.
module rst_stage_seq #(
    parameter int NUM_STAGES   = 3,
    parameter int STRETCH_CYC  = 16,
    parameter int SOFT_MIN_CYC = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sw_rst_req,
    output logic                  sw_rst_ack,
    output logic [NUM_STAGES-1:0] stage_rst_n,
    output logic                  rst_done
);

    localparam int CNT_MAX = (STRETCH_CYC > SOFT_MIN_CYC) ? STRETCH_CYC : SOFT_MIN_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH_CYC - 1);
    localparam logic [CW-1:0] SOFT_LAST    = CW'(SOFT_MIN_CYC - 1);
    localparam logic [CW-1:0] SOFT_SAT     = CW'(SOFT_MIN_CYC);
    localparam logic [IW-1:0] LAST_IDX     = IW'(NUM_STAGES - 1);

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_RELEASE,
        ST_DONE,
        ST_SOFT_HOLD
    } state_e;

    state_e                  state_q;
    logic [CW-1:0]           cnt_q;
    logic [IW-1:0]           idx_q;
    logic [NUM_STAGES-1:0]   stage_rst_n_q;
    logic                    rst_done_q;
    logic                    sw_rst_ack_q;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values and the update order inside the block does not matter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_ASSERT;
            cnt_q         <= '0;
            idx_q         <= '0;
            stage_rst_n_q <= '0;
            rst_done_q    <= 1'b0;
            sw_rst_ack_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    if (cnt_q == STRETCH_LAST) begin
                        stage_rst_n_q[0] <= 1'b1;
                        cnt_q            <= '0;
                        if (NUM_STAGES == 1) begin
                            state_q <= ST_DONE;
                        end else begin
                            idx_q   <= IW'(1);
                            state_q <= ST_RELEASE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                ST_RELEASE: begin
                    if (cnt_q == STRETCH_LAST) begin
                        stage_rst_n_q[idx_q] <= 1'b1;
                        cnt_q                <= '0;
                        if (idx_q == LAST_IDX) begin
                            state_q <= ST_DONE;
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                ST_DONE: begin
                    // A request still pending from power-on is taken here instead of raising done.
                    if (sw_rst_req) begin
                        stage_rst_n_q <= '0;
                        rst_done_q    <= 1'b0;
                        sw_rst_ack_q  <= 1'b1;
                        cnt_q         <= '0;
                        idx_q         <= '0;
                        state_q       <= ST_SOFT_HOLD;
                    end else begin
                        rst_done_q   <= 1'b1;
                        sw_rst_ack_q <= 1'b0;
                    end
                end

                ST_SOFT_HOLD: begin
                    // The entry edge counts as the first hold cycle, hence the compare against MIN-1.
                    if (cnt_q >= SOFT_LAST && !sw_rst_req) begin
                        cnt_q   <= '0;
                        state_q <= ST_ASSERT;
                    end else if (cnt_q != SOFT_SAT) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                default: begin
                    state_q <= ST_ASSERT;
                    cnt_q   <= '0;
                    idx_q   <= '0;
                end
            endcase
        end
    end

    assign stage_rst_n = stage_rst_n_q;
    assign rst_done    = rst_done_q;
    assign sw_rst_ack  = sw_rst_ack_q;

endmodule

// File: tb/tb_rst_stage_seq.sv
// Directed bench for rst_stage_seq: power-on sequencing, soft-reset handshake variants,
// async reset mid-sequence, and a minimal single-stage configuration.
module tb_rst_stage_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sw_rst_req = 1'b0;
    logic       sw_rst_ack;
    logic [2:0] stage_rst_n;
    logic       rst_done;

    logic       req1 = 1'b0;
    logic       ack1;
    logic [0:0] stage1;
    logic       done1;

    int cyc = 0;
    int base = 0;
    int total = 0;
    int passed = 0;

    typedef struct {
        int         e;
        logic [2:0] st;
        logic       dn;
        logic       ak;
    } vec_t;

    rst_stage_seq #(.NUM_STAGES(3), .STRETCH_CYC(16), .SOFT_MIN_CYC(8)) dut (
        .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_rst_req),
        .sw_rst_ack(sw_rst_ack), .stage_rst_n(stage_rst_n), .rst_done(rst_done)
    );

    rst_stage_seq #(.NUM_STAGES(1), .STRETCH_CYC(1), .SOFT_MIN_CYC(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .sw_rst_req(req1),
        .sw_rst_ack(ack1), .stage_rst_n(stage1), .rst_done(done1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Advance to 1ns after edge e, where edge 1 is the first posedge with rst_n high.
    task automatic goto(input int e);
        while (cyc - base < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        sw_rst_req = 1'b0;
        req1 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        base = cyc;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({stage_rst_n, rst_done, sw_rst_ack} !== 5'b000_0_0) begin
            $display("FAIL reset_main: got st=%b done=%b ack=%b, want 000/0/0", stage_rst_n, rst_done, sw_rst_ack);
        end else passed++;
        total++;
        if ({stage1, done1, ack1} !== 3'b0_0_0) begin
            $display("FAIL reset_single: got st=%b done=%b ack=%b, want 0/0/0", stage1, done1, ack1);
        end else passed++;
    endtask

    task automatic test_power_on();
        vec_t v[8];
        v = '{'{15, 3'b000, 1'b0, 1'b0}, '{16, 3'b001, 1'b0, 1'b0},
              '{31, 3'b001, 1'b0, 1'b0}, '{32, 3'b011, 1'b0, 1'b0},
              '{47, 3'b011, 1'b0, 1'b0}, '{48, 3'b111, 1'b0, 1'b0},
              '{49, 3'b111, 1'b1, 1'b0}, '{55, 3'b111, 1'b1, 1'b0}};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            goto(v[i].e);
            total++;
            if ({stage_rst_n, rst_done, sw_rst_ack} !== {v[i].st, v[i].dn, v[i].ak}) begin
                $display("FAIL power_on@%0d: got st=%b done=%b ack=%b, want %b/%b/%b",
                         v[i].e, stage_rst_n, rst_done, sw_rst_ack, v[i].st, v[i].dn, v[i].ak);
            end else passed++;
        end
    endtask

    task automatic test_soft_pulse();
        int s = 60;
        vec_t v[8];
        v = '{'{0, 3'b000, 1'b0, 1'b1}, '{7, 3'b000, 1'b0, 1'b1},
              '{8, 3'b000, 1'b0, 1'b1}, '{23, 3'b000, 1'b0, 1'b1},
              '{24, 3'b001, 1'b0, 1'b1}, '{40, 3'b011, 1'b0, 1'b1},
              '{56, 3'b111, 1'b0, 1'b1}, '{57, 3'b111, 1'b1, 1'b0}};
        goto(s - 1);
        @(negedge clk);
        sw_rst_req = 1'b1;
        goto(s);
        @(negedge clk);
        sw_rst_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            goto(s + v[i].e);
            total++;
            if ({stage_rst_n, rst_done, sw_rst_ack} !== {v[i].st, v[i].dn, v[i].ak}) begin
                $display("FAIL soft_pulse@S+%0d: got st=%b done=%b ack=%b, want %b/%b/%b",
                         v[i].e, stage_rst_n, rst_done, sw_rst_ack, v[i].st, v[i].dn, v[i].ak);
            end else passed++;
        end
    endtask

    task automatic test_soft_long();
        int s = 130;
        vec_t v[7];
        v = '{'{20, 3'b000, 1'b0, 1'b1}, '{21, 3'b000, 1'b0, 1'b1},
              '{36, 3'b000, 1'b0, 1'b1}, '{37, 3'b001, 1'b0, 1'b1},
              '{53, 3'b011, 1'b0, 1'b1}, '{69, 3'b111, 1'b0, 1'b1},
              '{70, 3'b111, 1'b1, 1'b0}};
        goto(s - 1);
        @(negedge clk);
        sw_rst_req = 1'b1;
        goto(s + 20);
        @(negedge clk);
        sw_rst_req = 1'b0;
        for (int i = 0; i < 7; i++) begin
            goto(s + v[i].e);
            total++;
            if ({stage_rst_n, rst_done, sw_rst_ack} !== {v[i].st, v[i].dn, v[i].ak}) begin
                $display("FAIL soft_long@S+%0d: got st=%b done=%b ack=%b, want %b/%b/%b",
                         v[i].e, stage_rst_n, rst_done, sw_rst_ack, v[i].st, v[i].dn, v[i].ak);
            end else passed++;
        end
    endtask

    task automatic test_req_during_power_on();
        vec_t v[8];
        v = '{'{16, 3'b001, 1'b0, 1'b0}, '{48, 3'b111, 1'b0, 1'b0},
              '{49, 3'b000, 1'b0, 1'b1}, '{56, 3'b000, 1'b0, 1'b1},
              '{72, 3'b000, 1'b0, 1'b1}, '{73, 3'b001, 1'b0, 1'b1},
              '{105, 3'b111, 1'b0, 1'b1}, '{106, 3'b111, 1'b1, 1'b0}};
        do_reset();
        goto(9);
        @(negedge clk);
        sw_rst_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            goto(v[i].e);
            total++;
            if ({stage_rst_n, rst_done, sw_rst_ack} !== {v[i].st, v[i].dn, v[i].ak}) begin
                $display("FAIL req_power_on@%0d: got st=%b done=%b ack=%b, want %b/%b/%b",
                         v[i].e, stage_rst_n, rst_done, sw_rst_ack, v[i].st, v[i].dn, v[i].ak);
            end else passed++;
            if (v[i].e == 49) begin
                @(negedge clk);
                sw_rst_req = 1'b0;
            end
        end
    endtask

    task automatic test_async_reset();
        vec_t v[4];
        v = '{'{15, 3'b000, 1'b0, 1'b0}, '{16, 3'b001, 1'b0, 1'b0},
              '{32, 3'b011, 1'b0, 1'b0}, '{48, 3'b111, 1'b0, 1'b0}};
        do_reset();
        goto(20);
        total++;
        if (stage_rst_n !== 3'b001) begin
            $display("FAIL async_pre: got st=%b, want 001", stage_rst_n);
        end else passed++;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({stage_rst_n, rst_done, sw_rst_ack} !== 5'b000_0_0) begin
            $display("FAIL async_drop: got st=%b done=%b ack=%b, want 000/0/0", stage_rst_n, rst_done, sw_rst_ack);
        end else passed++;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        base = cyc;
        for (int i = 0; i < 4; i++) begin
            goto(v[i].e);
            total++;
            if ({stage_rst_n, rst_done, sw_rst_ack} !== {v[i].st, v[i].dn, v[i].ak}) begin
                $display("FAIL async_restart@%0d: got st=%b done=%b ack=%b, want %b/%b/%b",
                         v[i].e, stage_rst_n, rst_done, sw_rst_ack, v[i].st, v[i].dn, v[i].ak);
            end else passed++;
        end
    endtask

    task automatic test_single_stage();
        int s = 5;
        vec_t v[6];
        v = '{'{1, 3'b001, 1'b0, 1'b0}, '{2, 3'b001, 1'b1, 1'b0},
              '{s, 3'b000, 1'b0, 1'b1}, '{s + 1, 3'b000, 1'b0, 1'b1},
              '{s + 2, 3'b001, 1'b0, 1'b1}, '{s + 3, 3'b001, 1'b1, 1'b0}};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (v[i].e == s) begin
                goto(s - 1);
                @(negedge clk);
                req1 = 1'b1;
            end
            goto(v[i].e);
            total++;
            if ({stage1, done1, ack1} !== {v[i].st[0], v[i].dn, v[i].ak}) begin
                $display("FAIL single@%0d: got st=%b done=%b ack=%b, want %b/%b/%b",
                         v[i].e, stage1, done1, ack1, v[i].st[0], v[i].dn, v[i].ak);
            end else passed++;
            if (v[i].e == s) begin
                @(negedge clk);
                req1 = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_soft_pulse();
        test_soft_long();
        test_req_during_power_on();
        test_async_reset();
        test_single_stage();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
